// File: rtl/rc_ctrl.sv
// Receive-side sequencer: arms rc_dpdm for a data or handshake packet, supervises
// sync timeout and packet watchdog, retries on errors and reports done/fail.
module rc_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int WDOG_CYC    = 128,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_data,
  input  logic       req_hshake,
  input  logic       cancel,
  input  logic       got_sync,
  input  logic       end_rc_nrzi,
  input  logic       EOP_error,
  input  logic       pkt_bad,
  output logic       receive_data,
  output logic       receive_hshake,
  output logic       rc_EOPerr,
  output logic       abort,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [3:0] retry_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LISTEN, S_RECV, S_EOP1, S_EOP2, S_ERRACK, S_ABORT, S_DONE
  } state_t;

  localparam logic [9:0] TO_LAST   = 10'(TIMEOUT_CYC - 1);
  localparam logic [9:0] WD_LAST   = 10'(WDOG_CYC - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  state_t     state_q, state_d;
  logic [9:0] timer_q, timer_d;
  logic [3:0] retry_q, retry_d;
  logic       is_data_q, is_data_d;
  logic       cxl_q, cxl_d;

  logic [9:0] timer_inc;
  logic       retry_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      retry_q   <= '0;
      is_data_q <= 1'b1;
      cxl_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      is_data_q <= is_data_d;
      cxl_q     <= cxl_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    retry_d    = retry_q;
    is_data_d  = is_data_q;
    cxl_d      = cxl_q;
    timer_inc  = (timer_q == 10'h3FF) ? timer_q : timer_q + 10'd1;
    retry_last = (retry_q == RETRY_MAX);

    case (state_q)
      S_IDLE: begin
        if (req_data || req_hshake) begin
          is_data_d = req_data;
          retry_d   = '0;
          timer_d   = '0;
          cxl_d     = 1'b0;
          state_d   = S_LISTEN;
        end
      end
      S_LISTEN: begin
        timer_d = timer_inc;
        if (cancel) begin
          state_d = S_ABORT;
          cxl_d   = 1'b1;
        end else if (got_sync) begin
          timer_d = '0;
          state_d = S_RECV;
        end else if (timer_q == TO_LAST) begin
          state_d = S_ABORT;
        end
      end
      S_RECV: begin
        timer_d = timer_inc;
        if (cancel) begin
          state_d = S_ABORT;
          cxl_d   = 1'b1;
        end else if (end_rc_nrzi && EOP_error) begin
          state_d = S_ERRACK;
        end else if (end_rc_nrzi) begin
          state_d = S_EOP1;
        end else if (timer_q == WD_LAST) begin
          state_d = S_ABORT;
        end
      end
      S_EOP1: begin
        if (cancel) begin
          state_d = S_ABORT;
          cxl_d   = 1'b1;
        end else if (EOP_error) begin
          state_d = S_ERRACK;
        end else begin
          state_d = S_EOP2;
        end
      end
      S_EOP2: begin
        if (cancel) begin
          state_d = S_ABORT;
          cxl_d   = 1'b1;
        end else if (EOP_error) begin
          state_d = S_ERRACK;
        end else if (pkt_bad) begin
          state_d = S_ABORT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_ERRACK: begin
        if (cancel) begin
          state_d = S_ABORT;
          cxl_d   = 1'b1;
        end else if (retry_last) begin
          state_d = S_IDLE;
        end else begin
          retry_d = retry_q + 4'd1;
          timer_d = '0;
          state_d = S_LISTEN;
        end
      end
      S_ABORT: begin
        // A cancel-initiated abort leaves the retry count alone and never reports.
        if (cxl_q) begin
          cxl_d   = 1'b0;
          state_d = S_IDLE;
        end else if (retry_last) begin
          state_d = S_IDLE;
        end else begin
          retry_d = retry_q + 4'd1;
          timer_d = '0;
          state_d = S_LISTEN;
        end
      end
      S_DONE: begin
        if (cancel) begin
          state_d = S_ABORT;
          cxl_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic listening;

  always_comb begin
    listening      = (state_q == S_LISTEN) || (state_q == S_RECV) ||
                     (state_q == S_EOP1)   || (state_q == S_EOP2);
    receive_data   = listening && is_data_q;
    receive_hshake = listening && !is_data_q;
    rc_EOPerr      = (state_q == S_ERRACK);
    abort          = (state_q == S_ABORT);
    busy           = (state_q != S_IDLE);
    done           = (state_q == S_DONE);
    fail           = ((state_q == S_ERRACK) || ((state_q == S_ABORT) && !cxl_q)) &&
                     (retry_q == RETRY_MAX);
    retry_cnt      = retry_q;
  end

endmodule

// File: tb/tb_rc_ctrl.sv
// Bench for rc_ctrl: directed scenarios plus randomized multi-attempt packets
// compared against a per-attempt timeline model.
module tb_rc_ctrl;

  localparam int T  = 8;
  localparam int W  = 20;
  localparam int MR = 2;

  logic clk = 1'b0;
  logic rst_n, req_data, req_hshake, cancel, got_sync, end_rc_nrzi, EOP_error, pkt_bad;
  logic receive_data, receive_hshake, rc_EOPerr, abort, busy, done, fail;
  logic [3:0] retry_cnt;
  logic receive_data_z, receive_hshake_z, rc_EOPerr_z, abort_z, busy_z, done_z, fail_z;
  logic [3:0] retry_cnt_z;

  rc_ctrl #(.TIMEOUT_CYC(T), .WDOG_CYC(W), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .req_data(req_data), .req_hshake(req_hshake),
    .cancel(cancel), .got_sync(got_sync), .end_rc_nrzi(end_rc_nrzi),
    .EOP_error(EOP_error), .pkt_bad(pkt_bad), .receive_data(receive_data),
    .receive_hshake(receive_hshake), .rc_EOPerr(rc_EOPerr), .abort(abort),
    .busy(busy), .done(done), .fail(fail), .retry_cnt(retry_cnt));

  rc_ctrl #(.TIMEOUT_CYC(T), .WDOG_CYC(W), .MAX_RETRY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_data(req_data), .req_hshake(req_hshake),
    .cancel(cancel), .got_sync(got_sync), .end_rc_nrzi(end_rc_nrzi),
    .EOP_error(EOP_error), .pkt_bad(pkt_bad), .receive_data(receive_data_z),
    .receive_hshake(receive_hshake_z), .rc_EOPerr(rc_EOPerr_z), .abort(abort_z),
    .busy(busy_z), .done(done_z), .fail(fail_z), .retry_cnt(retry_cnt_z));

  always #5 clk = ~clk;

  logic [10:0] obs, obs_z;
  assign obs   = {receive_data, receive_hshake, rc_EOPerr, abort, busy, done, fail, retry_cnt};
  assign obs_z = {receive_data_z, receive_hshake_z, rc_EOPerr_z, abort_z, busy_z, done_z,
                  fail_z, retry_cnt_z};

  typedef struct packed {
    logic req_d; logic req_h; logic sync; logic endn; logic eop; logic bad; logic cxl;
  } stim_t;
  typedef struct packed {
    logic rd; logic rh; logic err; logic abt; logic busy; logic dn; logic fl; logic [3:0] rc;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    att_kind[16], att_d[16], att_l[16];
  int    n_chk = 0, n_pass = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    req_data = 0; req_hshake = 0; cancel = 0; got_sync = 0;
    end_rc_nrzi = 0; EOP_error = 0; pkt_bad = 0;
  endtask

  task automatic apply(input stim_t s);
    req_data = s.req_d; req_hshake = s.req_h; got_sync = s.sync;
    end_rc_nrzi = s.endn; EOP_error = s.eop; pkt_bad = s.bad; cancel = s.cxl;
  endtask

  task automatic quiesce();
    clr_in();
    cancel = 1;
    tick();
    cancel = 0;
    repeat (3) tick();
  endtask

  function automatic stim_t mk(input bit sy, input bit en, input bit eo, input bit bd);
    stim_t s;
    s = '0; s.sync = sy; s.endn = en; s.eop = eo; s.bad = bd;
    return s;
  endfunction

  // Kinds: 0 sync timeout, 1 clean, 2 EOP error at end, 3 EOP error in EOP1,
  // 4 EOP error in EOP2, 5 bad packet, 6 watchdog.
  task automatic build(input bit rq_d, input bit rq_h, input int n_att);
    stim_t s;
    exp_t  e, lst;
    int    rc, k, kind, term;
    bit    fin;
    stim_q.delete(); exp_q.delete();
    s = '0; s.req_d = rq_d; s.req_h = rq_h;
    e = '0;
    stim_q.push_back(s); exp_q.push_back(e);
    rc = 0; fin = 0; k = 0;
    while (!fin) begin
      kind = (k < n_att) ? att_kind[k] : 0;
      lst = '0; lst.rd = rq_d; lst.rh = !rq_d; lst.busy = 1; lst.rc = 4'(rc);
      term = 0;
      if (kind == 0) begin
        for (int i = 0; i < T; i++) begin
          stim_q.push_back(mk(0, 0, 0, 1'($urandom))); exp_q.push_back(lst);
        end
        term = 2;
      end else begin
        for (int i = 0; i <= att_d[k]; i++) begin
          stim_q.push_back(mk(i == att_d[k], 0, 0, 1'($urandom))); exp_q.push_back(lst);
        end
        if (kind == 6) begin
          for (int i = 0; i < W; i++) begin
            stim_q.push_back(mk(0, 0, 0, 1'($urandom))); exp_q.push_back(lst);
          end
          term = 2;
        end else begin
          for (int i = 0; i <= att_l[k]; i++) begin
            stim_q.push_back(mk(0, i == att_l[k], (i == att_l[k]) && kind == 2, 1'($urandom)));
            exp_q.push_back(lst);
          end
          if (kind == 2) term = 1;
          else begin
            stim_q.push_back(mk(0, 0, kind == 3, 1'($urandom))); exp_q.push_back(lst);
            if (kind == 3) term = 1;
            else begin
              stim_q.push_back(mk(0, 0, kind == 4, kind == 5)); exp_q.push_back(lst);
              if (kind == 4) term = 1;
              else if (kind == 5) term = 2;
              else begin
                e = '0; e.busy = 1; e.dn = 1; e.rc = 4'(rc);
                stim_q.push_back(mk(0, 0, 0, 0)); exp_q.push_back(e);
                fin = 1;
              end
            end
          end
        end
      end
      if (term != 0) begin
        e = '0; e.busy = 1; e.err = (term == 1); e.abt = (term == 2);
        e.fl = (rc == MR); e.rc = 4'(rc);
        stim_q.push_back(mk(0, 0, 0, 0)); exp_q.push_back(e);
        if (rc == MR) fin = 1;
        else rc++;
      end
      k++;
    end
    e = '0; e.rc = 4'(rc);
    stim_q.push_back(mk(0, 0, 0, 0)); exp_q.push_back(e);
  endtask

  task automatic run_trace(input string nm);
    logic [10:0] want;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      want = exp_q[i];
      n_chk++;
      // The first cycle still shows the previous request's retry count.
      if ((i == 0) ? (obs[10:4] !== want[10:4]) : (obs !== want))
        $display("FAIL %s cyc %0d: got %b want %b", nm, i, obs, want);
      else n_pass++;
      apply(stim_q[i]);
    end
    clr_in();
  endtask

  task automatic test_reset();
    clr_in();
    rst_n = 0;
    #12;
    n_chk++;
    if (obs !== 11'b0 || obs_z !== 11'b0) $display("FAIL reset_hold: got %b/%b want 0", obs, obs_z);
    else n_pass++;
    @(negedge clk) rst_n = 1;
    tick();
    n_chk++;
    if (obs !== 11'b0) $display("FAIL reset_release: got %b want 0", obs);
    else n_pass++;
  endtask

  task automatic test_hshake_good();
    logic [2:0] want;
    for (int c = 0; c <= 18; c++) begin
      tick();
      want = {1'b0, (c >= 1 && c <= 16), c == 17};
      n_chk++;
      if ({receive_data, receive_hshake, done} !== want)
        $display("FAIL hshake_good cyc %0d: got rd/rh/done %b want %b", c,
                 {receive_data, receive_hshake, done}, want);
      else n_pass++;
      if (c == 17) begin
        n_chk++;
        if (retry_cnt !== 4'd0) $display("FAIL hshake_retry: got %0d want 0", retry_cnt);
        else n_pass++;
      end
      if (c == 18) begin
        n_chk++;
        if (busy !== 1'b0) $display("FAIL hshake_busy_fall: got %b want 0", busy);
        else n_pass++;
      end
      clr_in();
      req_hshake = (c == 0); got_sync = (c == 5); end_rc_nrzi = (c == 14);
    end
    quiesce();
  endtask

  task automatic test_timeout_fail();
    int ab[$];
    int fail_c = -1, fail_rc = -1;
    logic busy_after = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      tick();
      if (abort) ab.push_back(c);
      if (fail) begin fail_c = c; fail_rc = int'(retry_cnt); end
      if (c == 28) busy_after = busy;
      clr_in();
      req_data = (c == 0);
    end
    n_chk++;
    if (ab.size() != 3) $display("FAIL timeout_abort_count: got %0d want 3", ab.size());
    else begin
      n_pass++;
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (ab[i] != 9 * (i + 1)) $display("FAIL timeout_abort_cyc%0d: got %0d want %0d", i, ab[i], 9 * (i + 1));
        else n_pass++;
      end
    end
    n_chk++;
    if (fail_c != 27 || fail_rc != 2)
      $display("FAIL timeout_fail: got cyc %0d rc %0d want cyc 27 rc 2", fail_c, fail_rc);
    else n_pass++;
    n_chk++;
    if (busy_after !== 1'b0) $display("FAIL timeout_busy: got %b want 0", busy_after);
    else n_pass++;
    quiesce();
  endtask

  task automatic test_eop1_err_retry();
    att_kind[0] = 3; att_d[0] = 2; att_l[0] = 3;
    att_kind[1] = 1; att_d[1] = 0; att_l[1] = 0;
    build(1, 0, 2);
    run_trace("eop1_err");
    quiesce();
  endtask

  task automatic test_pkt_bad_mr0();
    int n_ab = 0, ab_c = -1, fl_c = -1, fl_rc = -1;
    bit dn = 0;
    for (int c = 0; c <= 12; c++) begin
      tick();
      if (abort_z) begin n_ab++; ab_c = c; end
      if (fail_z) begin fl_c = c; fl_rc = int'(retry_cnt_z); end
      if (done_z) dn = 1;
      clr_in();
      req_data = (c == 0); got_sync = (c == 2); end_rc_nrzi = (c == 4); pkt_bad = (c == 6);
    end
    n_chk++;
    if (n_ab != 1 || ab_c != 7) $display("FAIL pktbad_abort: got n %0d cyc %0d want n 1 cyc 7", n_ab, ab_c);
    else n_pass++;
    n_chk++;
    if (fl_c != 7 || fl_rc != 0) $display("FAIL pktbad_fail: got cyc %0d rc %0d want cyc 7 rc 0", fl_c, fl_rc);
    else n_pass++;
    n_chk++;
    if (dn) $display("FAIL pktbad_done: got done want none");
    else n_pass++;
    quiesce();
  endtask

  task automatic test_cancel();
    int n_ab = 0, last_ab = -1;
    bit df = 0;
    logic [4:0] at16 = '1;
    for (int c = 0; c <= 20; c++) begin
      tick();
      if (abort) begin n_ab++; last_ab = c; end
      if (done || fail) df = 1;
      if (c == 16) at16 = {busy, retry_cnt};
      clr_in();
      req_data = (c == 0); got_sync = (c == 11); cancel = (c == 14);
    end
    n_chk++;
    if (n_ab != 2 || last_ab != 15) $display("FAIL cancel_abort: got n %0d last %0d want n 2 last 15", n_ab, last_ab);
    else n_pass++;
    n_chk++;
    if (df) $display("FAIL cancel_no_report: got done/fail want none");
    else n_pass++;
    n_chk++;
    if (at16 !== 5'b0_0001) $display("FAIL cancel_idle: got busy/rc %b want 00001", at16);
    else n_pass++;
  endtask

  task automatic test_same_cycle_busy();
    for (int c = 0; c <= 4; c++) begin
      tick();
      if (c == 1 || c == 3) begin
        n_chk++;
        if ({receive_data, receive_hshake, busy} !== 3'b101)
          $display("FAIL same_cycle cyc %0d: got rd/rh/busy %b want 101", c,
                   {receive_data, receive_hshake, busy});
        else n_pass++;
      end
      clr_in();
      req_data = (c == 0); req_hshake = (c == 0) || (c == 2);
    end
    quiesce();
  endtask

  task automatic test_random();
    bit rd, rh;
    for (int sc = 0; sc < 12; sc++) begin
      for (int k = 0; k < 4; k++) begin
        att_kind[k] = int'($urandom_range(6, 0));
        att_d[k]    = int'($urandom_range(T - 1, 0));
        att_l[k]    = int'($urandom_range(W - 1, 0));
      end
      rd = 1'($urandom);
      rh = rd ? 1'($urandom) : 1'b1;
      build(rd, rh, 4);
      run_trace($sformatf("random%0d", sc));
      quiesce();
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c <= 5; c++) begin
      tick();
      clr_in();
      req_data = (c == 0); got_sync = (c == 2);
    end
    #2 rst_n = 0;
    #1;
    n_chk++;
    if (obs !== 11'b0 || obs_z !== 11'b0) $display("FAIL async_reset: got %b/%b want 0", obs, obs_z);
    else n_pass++;
    clr_in();
    @(negedge clk) rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++;
      if (obs !== 11'b0) $display("FAIL post_reset cyc %0d: got %b want 0", c, obs);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_hshake_good();
    test_timeout_fail();
    test_eop1_err_retry();
    test_pkt_bad_mr0();
    test_cancel();
    test_same_cycle_busy();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rc_ctrl.md
# rc_ctrl

Receive-side sequencer for the USB host's downstream receive datapath (rc_dpdm → rc_nrzi → unstuff/CRC). It accepts a one-cycle request from the protocol layer to listen for either a data packet or a handshake. It holds the matching `receive_*` level to rc_dpdm and runs a sync-timeout and packet watchdog. On EOP errors it acknowledges with `rc_EOPerr`; on timeouts it issues `abort`. It retries up to a bounded count and reports a single `done` or `fail` pulse per request.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 255: cycles spent in LISTEN without `got_sync` before an abort/retry; legal range 2..1023.
- `WDOG_CYC`, default 128: maximum cycles spent in RECV before an abort/retry; legal range 2..1023.
- `MAX_RETRY`, default 3: number of retries after the first attempt; legal range 0..15.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset: one clock; reset is asynchronous and active-low.
- `req_data`  in  1  one-cycle pulse: receive an 88-bit data packet.
- `req_hshake`  in  1  one-cycle pulse: receive an 8-bit handshake.
- `cancel`  in  1  synchronous cancel of the current request.
- `got_sync`  in  1  from rc_dpdm: SYNC detected.
- `end_rc_nrzi`  in  1  from rc_dpdm: final packet bit consumed.
- `EOP_error`  in  1  from rc_dpdm: bad EOP.
- `pkt_bad`  in  1  from the CRC/PID checker; valid in the DONE-decision cycle.
- `receive_data`  out  1  to rc_dpdm, level.
- `receive_hshake`  out  1  to rc_dpdm, level.
- `rc_EOPerr`  out  1  to rc_dpdm: error acknowledge, one-cycle pulse.
- `abort`  out  1  to rc_dpdm: synchronous reset, one-cycle pulse.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse: good packet received.
- `fail`  out  1  one-cycle pulse: retries exhausted.
- `retry_cnt`  out  4  retries used by the current or last request.

## Operation
- States: IDLE, LISTEN, RECV, EOP1, EOP2, ERRACK, ABORT, DONE.
- Outputs are Moore-decoded from state and registered type/counter flops:
  - `receive_*` is high in LISTEN, RECV, EOP1 and EOP2, selected by the latched type.
  - `rc_EOPerr` is high only in ERRACK.
  - `abort` is high only in ABORT.
- IDLE:
  - On `req_data` or `req_hshake`, latch the type, clear `retry_cnt` and the timer, and go to LISTEN.
  - If both requests arrive in the same cycle, data wins.
  - `cancel` is ignored in IDLE.
- LISTEN:
  - The timer increments every cycle.
  - `got_sync` → RECV and clear the timer.
  - If the timer equals `TIMEOUT_CYC-1` without `got_sync` → ABORT.
- RECV:
  - The timer increments every cycle.
  - `end_rc_nrzi` with `EOP_error` → ERRACK.
  - `end_rc_nrzi` without `EOP_error` → EOP1.
  - If the timer equals `WDOG_CYC-1` → ABORT.
- EOP1:
  - `EOP_error` → ERRACK.
  - Otherwise → EOP2.
- EOP2:
  - `EOP_error` → ERRACK.
  - Otherwise, `pkt_bad` → ABORT (treated as a retryable failure).
  - Otherwise → DONE.
- ERRACK and ABORT (one cycle each):
  - If `retry_cnt == MAX_RETRY`: pulse `fail` in this same cycle and go to IDLE.
  - Else: increment `retry_cnt`, clear the timer, and go to LISTEN.
- DONE: pulse `done` and go to IDLE.
- `cancel` in any non-IDLE state other than ABORT → ABORT, then unconditionally IDLE.
  - A cancel-initiated abort does not count a retry, does not pulse `fail`, and does not pulse `done`.
- New requests while `busy` are ignored (not queued).
- Priority within one cycle: `cancel` > `EOP_error` > `end_rc_nrzi` > timer expiry.
- Timer is 10 bits and saturates (no wrap). `retry_cnt` never exceeds `MAX_RETRY`.
- `MAX_RETRY=0`: the first error or timeout produces `fail` with `retry_cnt=0`.

## Timing
- Reset values: state IDLE. Every output is 0, including `retry_cnt=0`. Timer is 0 and the latched type is data.
- `receive_*` rises in the cycle after the request pulse.
- Sync timeout: with no sync, `abort` is high exactly `TIMEOUT_CYC` cycles after LISTEN entry.
- Good packet: `done` is high 3 cycles after the `end_rc_nrzi` cycle (EOP1, EOP2, DONE).
- `busy` falls in the cycle after DONE.
- `rc_EOPerr` is high the cycle after the `EOP_error` is sampled. `receive_*` is low during ERRACK and ABORT.
- If `rst_n` is asserted mid-packet, all outputs drop to 0 asynchronously. No `done` or `fail` pulse is emitted.
- Every accepted request yields exactly one `done` or `fail`, or neither if cancelled.

## Test plan
- Hshake request, then `got_sync` at cycle 5, then `end_rc_nrzi` at cycle 14 with clean EOP and `pkt_bad=0`:
  - `receive_hshake` is high from cycle 1 through 16.
  - `done` pulses at cycle 17. `retry_cnt=0`.
- Data request, no sync, `TIMEOUT_CYC=8`, `MAX_RETRY=2`:
  - Three `abort` pulses, 9 cycles apart.
  - `fail` on the third abort. `retry_cnt=2`.
- Data request, sync, `EOP_error` in the EOP1 cycle:
  - One-cycle `rc_EOPerr`, then back to LISTEN with `retry_cnt=1`.
  - A clean second packet → `done`.
- `pkt_bad=1` at EOP2 with `MAX_RETRY=0` → single `abort` and `fail`. No `done`.
- `cancel` during RECV → one `abort` pulse, then IDLE. No `done`/`fail`. `retry_cnt` is unchanged.
- Same-cycle `req_data`/`req_hshake` → data latched.
  - A request during `busy` is ignored.
  - `rst_n` low mid-RECV → all outputs 0 immediately.
